// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection, hazard detection, stall and flush.
// Optional macro ID_EX_FORWARD_EN adds EX/MEM and MEM/WB forwarding; without it, RAW hazards stall.
module id_ex_stage #(
    parameter int DATAWIDTH    = 32,
    parameter int ALUOPWIDTH   = 4,
    parameter int REGADDRWIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REGADDRWIDTH-1:0] id_rs1_addr,
    input  logic [REGADDRWIDTH-1:0] id_rs2_addr,
    input  logic [DATAWIDTH-1:0]    id_rs1_data,
    input  logic [DATAWIDTH-1:0]    id_rs2_data,
    input  logic [DATAWIDTH-1:0]    id_imm,
    input  logic                    id_use_imm,
    input  logic [ALUOPWIDTH-1:0]   id_aluop,
    input  logic [REGADDRWIDTH-1:0] id_rd_addr,
    input  logic                    id_rd_we,
    input  logic                    id_is_load,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic [REGADDRWIDTH-1:0] exm_rd_addr,
    input  logic                    exm_rd_we,
    input  logic                    exm_is_load,
    input  logic [DATAWIDTH-1:0]    exm_result,
    input  logic [REGADDRWIDTH-1:0] mwb_rd_addr,
    input  logic                    mwb_rd_we,
    input  logic [DATAWIDTH-1:0]    mwb_result,
    output logic [DATAWIDTH-1:0]    alu_src1,
    output logic [DATAWIDTH-1:0]    alu_src2,
    output logic [ALUOPWIDTH-1:0]   alu_aluop,
    output logic                    ex_valid,
    output logic [REGADDRWIDTH-1:0] ex_rd_addr,
    output logic                    ex_rd_we,
    output logic                    ex_is_load,
    output logic                    id_stall
);

    logic [REGADDRWIDTH-1:0] ex_rs1_addr;
    logic [REGADDRWIDTH-1:0] ex_rs2_addr;
    logic [DATAWIDTH-1:0]    ex_rs1_data;
    logic [DATAWIDTH-1:0]    ex_rs2_data;
    logic [DATAWIDTH-1:0]    ex_imm;
    logic                    ex_use_imm;
    logic                    hazard;
    logic [DATAWIDTH-1:0]    opnd1;
    logic [DATAWIDTH-1:0]    opnd2;

    // Producer stage load status is not needed: only the EX stage load matters for load-use.
    logic unused_exm_is_load;
    assign unused_exm_is_load = exm_is_load;

`ifdef ID_EX_FORWARD_EN
    logic rs2_used;
    assign rs2_used = !id_use_imm && (ex_rd_addr == id_rs2_addr);
    assign hazard = id_valid && ex_valid && ex_is_load && ex_rd_we && (ex_rd_addr != '0)
                    && ((ex_rd_addr == id_rs1_addr) || rs2_used);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        opnd1 = ex_rs1_data;
        if (exm_rd_we && (exm_rd_addr == ex_rs1_addr) && (ex_rs1_addr != '0))
            opnd1 = exm_result;
        else if (mwb_rd_we && (mwb_rd_addr == ex_rs1_addr) && (ex_rs1_addr != '0))
            opnd1 = mwb_result;

        opnd2 = ex_rs2_data;
        if (exm_rd_we && (exm_rd_addr == ex_rs2_addr) && (ex_rs2_addr != '0))
            opnd2 = exm_result;
        else if (mwb_rd_we && (mwb_rd_addr == ex_rs2_addr) && (ex_rs2_addr != '0))
            opnd2 = mwb_result;
    end
`else
    logic rs1_need, rs2_need, ex_writes;
    logic rs1_hit, rs2_hit;
    assign rs1_need  = id_rs1_addr != '0;
    assign rs2_need  = !id_use_imm && (id_rs2_addr != '0);
    assign ex_writes = ex_valid && ex_rd_we;
    assign rs1_hit   = (ex_writes && (ex_rd_addr == id_rs1_addr))
                     || (exm_rd_we && (exm_rd_addr == id_rs1_addr));
    assign rs2_hit   = (ex_writes && (ex_rd_addr == id_rs2_addr))
                     || (exm_rd_we && (exm_rd_addr == id_rs2_addr));
    // MEM/WB needs no stall: the register file writes before it is read.
    assign hazard    = id_valid && ((rs1_need && rs1_hit) || (rs2_need && rs2_hit));
    assign opnd1     = ex_rs1_data;
    assign opnd2     = ex_rs2_data;

    logic unused_fwd;
    assign unused_fwd = ^{exm_result, mwb_rd_addr, mwb_rd_we, mwb_result, ex_rs1_addr, ex_rs2_addr};
`endif

    assign alu_src1 = opnd1;
    assign alu_src2 = ex_use_imm ? ex_imm : opnd2;
    assign id_stall = stall_in || (hazard && !flush);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid    <= 1'b0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_use_imm  <= 1'b0;
            alu_aluop   <= '0;
            ex_rd_addr  <= '0;
            ex_rd_we    <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (!stall_in) begin
            if (hazard) begin
                ex_valid   <= 1'b0;
                ex_rd_we   <= 1'b0;
                ex_is_load <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_rs1_addr <= id_rs1_addr;
                ex_rs2_addr <= id_rs2_addr;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_use_imm  <= id_use_imm;
                alu_aluop   <= id_aluop;
                ex_rd_addr  <= id_rd_addr;
                ex_rd_we    <= id_rd_we;
                ex_is_load  <= id_is_load;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expectations, a negedge monitor pops and compares.
// Expectations follow the ID_EX_FORWARD_EN build selection.
module tb_id_ex_stage;

    typedef enum logic [2:0] {
        S_VALID, S_RDADDR, S_RDWE, S_ISLOAD, S_ALUOP, S_SRC1, S_SRC2, S_STALL
    } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_aluop;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we, id_is_load;
    logic        stall_in, flush;
    logic [4:0]  exm_rd_addr;
    logic        exm_rd_we, exm_is_load;
    logic [31:0] exm_result;
    logic [4:0]  mwb_rd_addr;
    logic        mwb_rd_we;
    logic [31:0] mwb_result;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_aluop;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we, ex_is_load;
    logic        id_stall;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_aluop(id_aluop),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .stall_in(stall_in), .flush(flush),
        .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_is_load(exm_is_load),
        .exm_result(exm_result),
        .mwb_rd_addr(mwb_rd_addr), .mwb_rd_we(mwb_rd_we), .mwb_result(mwb_result),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_aluop(alu_aluop),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    // Monitor: drains every expectation queued during the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                S_VALID:  act = {31'd0, ex_valid};
                S_RDADDR: act = {27'd0, ex_rd_addr};
                S_RDWE:   act = {31'd0, ex_rd_we};
                S_ISLOAD: act = {31'd0, ex_is_load};
                S_ALUOP:  act = {28'd0, alu_aluop};
                S_SRC1:   act = alu_src1;
                S_SRC2:   act = alu_src2;
                default:  act = {31'd0, id_stall};
            endcase
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input string name, input sel_t sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2,
                            input logic use_imm, input logic [31:0] imm,
                            input logic [3:0] op, input logic [4:0] rd,
                            input logic we, input logic ld);
        id_valid    = 1'b1;
        id_rs1_addr = rs1;  id_rs1_data = d1;
        id_rs2_addr = rs2;  id_rs2_data = d2;
        id_use_imm  = use_imm;
        id_imm      = imm;
        id_aluop    = op;
        id_rd_addr  = rd;
        id_rd_we    = we;
        id_is_load  = ld;
    endtask

    task automatic clear_fwd();
        exm_rd_addr = '0; exm_rd_we = 1'b0; exm_is_load = 1'b0; exm_result = '0;
        mwb_rd_addr = '0; mwb_rd_we = 1'b0; mwb_result = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        clear_fwd();
        id_instr(5'd1, 32'h5, 5'd2, 32'h6, 1'b0, 32'h7, 4'd3, 5'd4, 1'b1, 1'b1);

        // Reset held two edges with a valid instruction at the ID inputs.
        tick(); tick();
        expect_val("rst_valid", S_VALID, 0);
        expect_val("rst_aluop", S_ALUOP, 0);
        expect_val("rst_src1",  S_SRC1,  0);
        expect_val("rst_src2",  S_SRC2,  0);
        expect_val("rst_rdwe",  S_RDWE,  0);
        expect_val("rst_load",  S_ISLOAD, 0);
        expect_val("rst_rdaddr", S_RDADDR, 0);
        rst = 1'b0;
        id_valid = 1'b0;

        // Plain capture: rs1=x5 (0x11), rs2=x6 (0x22).
        id_instr(5'd5, 32'h11, 5'd6, 32'h22, 1'b0, 32'h0, 4'd3, 5'd7, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        expect_val("cap_valid", S_VALID, 1);
        expect_val("cap_aluop", S_ALUOP, 3);
        expect_val("cap_rd",    S_RDADDR, 7);
        expect_val("cap_src1",  S_SRC1, 32'h11);
        expect_val("cap_src2",  S_SRC2, 32'h22);
        expect_val("cap_stall", S_STALL, 0);

        // EX/MEM and MEM/WB both target x5.
        exm_rd_addr = 5'd5; exm_rd_we = 1'b1; exm_result = 32'h1234;
        mwb_rd_addr = 5'd5; mwb_rd_we = 1'b1; mwb_result = 32'h9999;
`ifdef ID_EX_FORWARD_EN
        expect_val("fwd_exm_prio", S_SRC1, 32'h1234);
`else
        expect_val("nofwd_src1", S_SRC1, 32'h11);
`endif
        tick();
        exm_rd_we = 1'b0;
`ifdef ID_EX_FORWARD_EN
        expect_val("fwd_mwb", S_SRC1, 32'h9999);
`else
        expect_val("nofwd_src1_mwb", S_SRC1, 32'h11);
`endif
        tick();
        clear_fwd();

        // x0 guard: rs2=x0 while EX/MEM writes x0 with all ones.
        id_instr(5'd1, 32'h1, 5'd0, 32'h0, 1'b0, 32'h0, 4'd0, 5'd2, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        exm_rd_addr = 5'd0; exm_rd_we = 1'b1; exm_result = 32'hFFFF_FFFF;
        expect_val("x0_src2", S_SRC2, 0);
        expect_val("x0_src1", S_SRC1, 1);
        tick();
        clear_fwd();

`ifdef ID_EX_FORWARD_EN
        // Load-use: lw x3 in EX, add reading x3 in ID.
        id_instr(5'd2, 32'h100, 5'd0, 32'h0, 1'b1, 32'h0, 4'd0, 5'd3, 1'b1, 1'b1);
        tick();
        id_instr(5'd3, 32'h0, 5'd4, 32'h4, 1'b0, 32'h0, 4'd0, 5'd5, 1'b1, 1'b0);
        expect_val("lu_stall", S_STALL, 1);
        expect_val("lu_ex_load", S_ISLOAD, 1);
        tick();
        exm_rd_addr = 5'd3; exm_rd_we = 1'b1; exm_is_load = 1'b1; exm_result = 32'h102;
        expect_val("lu_bubble_valid", S_VALID, 0);
        expect_val("lu_bubble_rdwe",  S_RDWE, 0);
        expect_val("lu_stall_done",   S_STALL, 0);
        tick();
        id_valid = 1'b0;
        clear_fwd();
        mwb_rd_addr = 5'd3; mwb_rd_we = 1'b1; mwb_result = 32'hABCD;
        expect_val("lu_valid", S_VALID, 1);
        expect_val("lu_src1",  S_SRC1, 32'hABCD);
        expect_val("lu_src2",  S_SRC2, 32'h4);
        tick();
        clear_fwd();
`else
        // RAW without forwarding: add x1 in EX, reader of x1 waits until x1 leaves EX/MEM.
        id_instr(5'd6, 32'h6, 5'd7, 32'h7, 1'b0, 32'h0, 4'd0, 5'd1, 1'b1, 1'b0);
        tick();
        id_instr(5'd1, 32'h0, 5'd8, 32'h8, 1'b0, 32'h0, 4'd0, 5'd4, 1'b1, 1'b0);
        expect_val("raw_stall_ex", S_STALL, 1);
        tick();
        exm_rd_addr = 5'd1; exm_rd_we = 1'b1; exm_result = 32'h77;
        expect_val("raw_bubble1", S_VALID, 0);
        expect_val("raw_stall_exm", S_STALL, 1);
        tick();
        exm_rd_we = 1'b0;
        mwb_rd_addr = 5'd1; mwb_rd_we = 1'b1; mwb_result = 32'h77;
        id_rs1_data = 32'h77;
        expect_val("raw_bubble2", S_VALID, 0);
        expect_val("raw_stall_mwb", S_STALL, 0);
        tick();
        id_valid = 1'b0;
        clear_fwd();
        expect_val("raw_valid", S_VALID, 1);
        expect_val("raw_src1",  S_SRC1, 32'h77);
        expect_val("raw_rd",    S_RDADDR, 4);
        tick();
`endif

        // Immediate operand, then a 3-cycle downstream stall.
        id_instr(5'd12, 32'h10, 5'd13, 32'h13, 1'b1, 32'hFFFF_FFF0, 4'd1, 5'd9, 1'b1, 1'b0);
        tick();
        id_instr(5'd14, 32'h14, 5'd15, 32'h15, 1'b0, 32'h0, 4'd5, 5'd10, 1'b1, 1'b0);
        stall_in = 1'b1;
        expect_val("imm_src2", S_SRC2, 32'hFFFF_FFF0);
        expect_val("imm_src1", S_SRC1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val("hold_valid", S_VALID, 1);
            expect_val("hold_aluop", S_ALUOP, 1);
            expect_val("hold_rd",    S_RDADDR, 9);
            expect_val("hold_src2",  S_SRC2, 32'hFFFF_FFF0);
            expect_val("hold_stall", S_STALL, 1);
        end

        // Flush together with stall: flush wins.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall_in = 1'b0;
        id_valid = 1'b0;
        expect_val("flush_valid", S_VALID, 0);
        expect_val("flush_aluop", S_ALUOP, 0);
        expect_val("flush_rdwe",  S_RDWE, 0);
        expect_val("flush_src2",  S_SRC2, 0);

        // Reset during a stall clears the stage.
        id_instr(5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 4'd7, 5'd11, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        expect_val("pre_rst_aluop", S_ALUOP, 7);
        stall_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_in = 1'b0;
        expect_val("rst_stall_valid", S_VALID, 0);
        expect_val("rst_stall_aluop", S_ALUOP, 0);

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                tick();
                budget--;
            end
            if (exp_q.size() > 0) begin
                failures++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It captures the decoded instruction each cycle and selects the ALU operands `alu_src1`/`alu_src2` combinationally, including forwarding from the EX/MEM and MEM/WB stages. It also detects load-use hazards and handles pipeline stall and flush, so the ALU always receives correct operands or a bubble.

## Interface
Parameters:
- `DATAWIDTH`, 32, operand and result width
- `ALUOPWIDTH`, 4, ALU opcode width (ADD=0 … SRA=9)
- `REGADDRWIDTH`, 5, register index width

Ports:
- `clk`  in  1  clock, single clock domain; all state updates on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs1_addr`, `id_rs2_addr`  in  REGADDRWIDTH  source register indices
- `id_rs1_data`, `id_rs2_data`  in  DATAWIDTH  register-file read data
- `id_imm`  in  DATAWIDTH  sign-extended immediate
- `id_use_imm`  in  1  src2 comes from the immediate, not rs2
- `id_aluop`  in  ALUOPWIDTH  ALU operation
- `id_rd_addr`  in  REGADDRWIDTH  destination register
- `id_rd_we`  in  1  instruction writes rd
- `id_is_load`  in  1  instruction is a load
- `stall_in`  in  1  downstream stall; hold EX contents
- `flush`  in  1  kill the instruction entering EX (branch redirect)
- `exm_rd_addr`, `exm_rd_we`, `exm_is_load`, `exm_result`  in  5/1/1/DATAWIDTH  EX/MEM stage state
- `mwb_rd_addr`, `mwb_rd_we`, `mwb_result`  in  5/1/DATAWIDTH  MEM/WB stage state
- `alu_src1`, `alu_src2`  out  DATAWIDTH  ALU operands (combinational)
- `alu_aluop`  out  ALUOPWIDTH  registered opcode
- `ex_valid`, `ex_rd_addr`, `ex_rd_we`, `ex_is_load`  out  1/5/1/1  registered control passed downstream
- `id_stall`  out  1  hold IF/ID this cycle (combinational)

## Operation
- EX register fields: valid, rs1/rs2 addr, rs1/rs2 data, imm, use_imm, aluop, rd_addr, rd_we, is_load.
- Rising-edge update priority: `rst` > `flush` > `stall_in` > hazard > load.
  - `rst` or `flush`: valid=0, rd_we=0, is_load=0, aluop=ADD (0), all data fields 0.
  - `stall_in`: hold all fields.
  - hazard: insert a bubble (valid=0, rd_we=0); ID holds its instruction.
  - otherwise: load the ID inputs; valid=`id_valid`.
- Load-use hazard = `id_valid` & `ex_valid` & `ex_is_load` & `ex_rd_we` & (`ex_rd_addr`≠0) & (`ex_rd_addr`==`id_rs1_addr` | (`ex_rd_addr`==`id_rs2_addr` & ~`id_use_imm`)).
- `id_stall` = `stall_in` | (hazard & ~`flush`).
- Operand select for each source rsN:
  - EX/MEM match (exm_rd_we, exm_rd_addr==rsN, rsN≠0) → `exm_result`.
  - else MEM/WB match → `mwb_result`.
  - else the registered register-file data.
  - EX/MEM has priority over MEM/WB.
  - Register x0 is never forwarded.
- `alu_src2` = registered imm when use_imm=1, otherwise the forwarded rs2.
- Operands are reselected every cycle, including while the stage is held by `stall_in`.
- When `ex_valid`=0, the operands are don't-care but must be deterministic: no X from reset state.

## Timing
- Latency: ID to EX register is 1 cycle. Operand mux is zero-cycle combinational.
- Load-use costs exactly 1 bubble cycle; the instruction enters EX on the next cycle and gets the load data via MEM/WB forwarding.
- Reset values: `ex_valid`=0, `ex_rd_we`=0, `ex_is_load`=0, `ex_rd_addr`=0, `alu_aluop`=0. `alu_src1`/`alu_src2` are 0 unless an external forward matches x0, which is excluded.
- `flush` together with `stall_in`: flush wins, valid=0 next cycle.
- `rst` mid-stall: the stage clears regardless of `stall_in`.

## Configuration
- `ID_EX_FORWARD_EN` defined:
  - Forwarding muxes are present.
  - Stalls only on load-use as above.
- Not defined:
  - `alu_src1`/`alu_src2` use the registered register-file data (or imm) directly.
  - Hazard = any valid rsN≠0 matching a writing rd in EX (`ex_rd_*`) or EX/MEM (`exm_rd_*`), regardless of is_load.
  - Each such hazard produces bubbles until the writer passes MEM/WB. The register file is write-before-read.

## Test plan
- Reset: assert `rst` 2 cycles with `id_valid`=1 → `ex_valid`=0, `alu_aluop`=0, `alu_src1`=`alu_src2`=0.
- EX/MEM forward: EX holds rs1=x5 with stale data 0x11; EX/MEM rd=x5, result 0x1234 → `alu_src1`=0x1234. Also set MEM/WB rd=x5, result 0x9999 → still 0x1234.
- x0 guard: rs2=x0, exm_rd_addr=0, exm_rd_we=1, result 0xFFFF_FFFF → `alu_src2`=0.
- Load-use: lw x3 in EX, ID add rs1=x3 → `id_stall`=1 for 1 cycle, bubble enters EX. Next cycle add is in EX with MEM/WB result 0xABCD → `alu_src1`=0xABCD.
- Immediate, stall, and flush: use_imm=1, imm=0xFFFF_FFF0 → `alu_src2`=0xFFFF_FFF0. Hold `stall_in` 3 cycles → EX fields unchanged. Assert `flush` with `stall_in` → `ex_valid`=0 next edge.
- Without `ID_EX_FORWARD_EN`: add x1 in EX/MEM, ID reads x1 → `id_stall` high until x1 passes MEM/WB (2 cycles). `alu_src1` then equals the register-file value.
